// File: rtl/syn_fifo_ctrl.sv
// Synchronous FIFO controller driving a 16x8 dual-port RAM with registered read data.
// Optional sticky overflow/underflow flags are compiled in with SYN_FIFO_ERR_EN.
module syn_fifo_ctrl #(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_DEPTH = 16,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [RAM_WIDTH-1:0] push_data,
  input  logic                 pop,
  output logic [RAM_WIDTH-1:0] pop_data,
  output logic                 pop_valid,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 ram_wr_en,
  output logic [ADDR_SIZE-1:0] ram_wr_ad,
  output logic [RAM_WIDTH-1:0] ram_data_in,
  output logic                 ram_rd_en,
  output logic [ADDR_SIZE-1:0] ram_rd_ad,
  input  logic [RAM_WIDTH-1:0] ram_data_out
`ifdef SYN_FIFO_ERR_EN
  ,
  output logic                 ovf_err,
  output logic                 unf_err
`endif
);

  typedef logic [ADDR_SIZE:0] ptr_t;
  localparam ptr_t PTR_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};

  if (RAM_DEPTH != (1 << ADDR_SIZE)) begin : g_depth_check
    $error("RAM_DEPTH must equal 2**ADDR_SIZE");
  end

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  logic pop_valid_q, pop_valid_d;
  logic push_ok, pop_ok;

  // Wrap bit (MSB) distinguishes full from empty when the addresses coincide.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_SIZE-1:0] == rd_ptr_q[ADDR_SIZE-1:0]) &&
                 (wr_ptr_q[ADDR_SIZE] != rd_ptr_q[ADDR_SIZE]);
  assign count = wr_ptr_q - rd_ptr_q;

  // Gating with rst keeps the RAM untouched for the whole reset cycle.
  assign push_ok = rst & push & ~full;
  assign pop_ok  = rst & pop & ~empty;

  assign ram_wr_en   = push_ok;
  assign ram_wr_ad   = wr_ptr_q[ADDR_SIZE-1:0];
  assign ram_data_in = push_data;
  assign ram_rd_en   = pop_ok;
  assign ram_rd_ad   = rd_ptr_q[ADDR_SIZE-1:0];

  assign pop_valid = pop_valid_q;
  assign pop_data  = ram_data_out;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pop_valid_d = pop_ok;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pop_valid_q <= pop_valid_d;
    end
  end

`ifdef SYN_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q | (push & full);
    unf_d = unf_q | (pop & empty);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
`endif

  a_count_range: assert property (@(posedge clk) disable iff (!rst)
    int'(count) <= RAM_DEPTH);

endmodule
